nmx_wb_fabric: RTL



---
 rtl/nmx_wb_fabric.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/nmx_wb_fabric.sv
// nmx_wb_fabric: shares one Wishbone slave port among NUM_SLV macro instances.
// Each instance owns a 2**WIN_BITS byte window above BASE_ADDR. One transaction
// is forwarded at a time, and every output comes straight from a flop.
// Optional watchdog: define NMX_WB_TIMEOUT_EN to end stalled transactions after TIMEOUT cycles.
module nmx_wb_fabric #(
    parameter int          NUM_SLV   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WIN_BITS  = 12,
    parameter int          TIMEOUT   = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_SLV-1:0]      s_cyc_o,
    output logic [NUM_SLV-1:0]      s_stb_o,
    output logic                    s_we_o,
    output logic [3:0]              s_sel_o,
    output logic [31:0]             s_adr_o,
    output logic [31:0]             s_dat_o,
    input  logic [32*NUM_SLV-1:0]   s_dat_i,
    input  logic [NUM_SLV-1:0]      s_ack_i,
    output logic                    busy_o,
    output logic                    timeout_o
);
    typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

    // Address bits above the whole fabric window must match BASE_ADDR.
    localparam logic [31:0] WIN_MASK = ~((32'(NUM_SLV) << WIN_BITS) - 32'd1);

    state_t              state_reg, state_next;
    logic [2:0]          idx_reg, idx_next;
    logic                ack_reg, ack_next;
    logic [31:0]         rdat_reg, rdat_next;
    logic [NUM_SLV-1:0]  stb_reg, stb_next;
    logic                we_reg, we_next;
    logic [3:0]          sel_reg, sel_next;
    logic [31:0]         adr_reg, adr_next;
    logic [31:0]         wdat_reg, wdat_next;
    logic                busy_reg, busy_next;
    logic                timeout_reg, timeout_next;
    logic                wdog_expire;

    logic [2:0]          req_idx;
    logic                req_hit;
    logic [NUM_SLV-1:0]  req_onehot;
    logic [31:0]         s_dat_arr [0:7];
    logic [7:0]          s_ack_ext;

    assign req_idx = wbs_adr_i[WIN_BITS +: 3];
    assign req_hit = ((wbs_adr_i & WIN_MASK) == BASE_ADDR) && ({1'b0, req_idx} < 4'(NUM_SLV));

    // Per-instance decode plus zero-padded 8-entry views so a 3-bit index is always in range.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_onehot
            assign req_onehot[gi] = (req_idx == 3'(gi));
        end
        for (gi = 0; gi < 8; gi++) begin : g_ext
            if (gi < NUM_SLV) begin : g_used
                assign s_dat_arr[gi] = s_dat_i[32*gi +: 32];
                assign s_ack_ext[gi] = s_ack_i[gi];
            end else begin : g_unused
                assign s_dat_arr[gi] = 32'h0;
                assign s_ack_ext[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef NMX_WB_TIMEOUT_EN
    logic [7:0] wdog_reg, wdog_next;

    // Counter runs only while forwarding; it is zero whenever FWD is entered.
    always_comb begin
        wdog_next = 8'd0;
        if (state_reg == FWD) begin
            wdog_next = wdog_reg + 8'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wdog_reg <= 8'd0;
        end else begin
            wdog_reg <= wdog_next;
        end
    end

    assign wdog_expire = ((wdog_reg + 8'd1) == 8'(TIMEOUT));
`else
    assign wdog_expire = 1'b0;
`endif

    // Next-state and next-output logic; only the selected instance's ack is honoured.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        ack_next     = 1'b0;
        rdat_next    = rdat_reg;
        stb_next     = stb_reg;
        we_next      = we_reg;
        sel_next     = sel_reg;
        adr_next     = adr_reg;
        wdat_next    = wdat_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (req_hit) begin
                        idx_next   = req_idx;
                        we_next    = wbs_we_i;
                        sel_next   = wbs_sel_i;
                        adr_next   = wbs_adr_i;
                        wdat_next  = wbs_dat_i;
                        stb_next   = req_onehot;
                        state_next = FWD;
                    end else begin
                        rdat_next  = 32'h0;
                        ack_next   = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            FWD: begin
                if (!wbs_cyc_i) begin
                    stb_next   = '0;
                    state_next = IDLE;
                end else if (s_ack_ext[idx_reg]) begin
                    rdat_next  = s_dat_arr[idx_reg];
                    stb_next   = '0;
                    ack_next   = 1'b1;
                    state_next = RESP;
                end else if (wdog_expire) begin
                    rdat_next    = 32'hBAD0_0000 | {29'h0, idx_reg};
                    stb_next     = '0;
                    ack_next     = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                stb_next   = '0;
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and output registers; asynchronous reset returns everything to idle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            idx_reg     <= 3'd0;
            ack_reg     <= 1'b0;
            rdat_reg    <= 32'h0;
            stb_reg     <= '0;
            we_reg      <= 1'b0;
            sel_reg     <= 4'h0;
            adr_reg     <= 32'h0;
            wdat_reg    <= 32'h0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            ack_reg     <= ack_next;
            rdat_reg    <= rdat_next;
            stb_reg     <= stb_next;
            we_reg      <= we_next;
            sel_reg     <= sel_next;
            adr_reg     <= adr_next;
            wdat_reg    <= wdat_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = rdat_reg;
    assign s_cyc_o   = stb_reg;
    assign s_stb_o   = stb_reg;
    assign s_we_o    = we_reg;
    assign s_sel_o   = sel_reg;
    assign s_adr_o   = adr_reg;
    assign s_dat_o   = wdat_reg;
    assign busy_o    = busy_reg;
    assign timeout_o = timeout_reg;
endmodule
